bus_master_8088: RTL and testbench

BUS_MASTER_8088 -- requirements
Module: bus_master_8088

---
 rtl/my_pkg.sv | 18 +
 rtl/bus_master_8088_if.sv | 45 ++++
 rtl/bus_wait_timer.sv | 37 +++
 rtl/bus_master_8088.sv | 161 ++++++++++++++++
 tb/tb_bus_master_8088.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/my_pkg.sv
// Shared definitions for the 8088 minimum-mode bus master.
//   bus_state_t      : bus-cycle FSM states (IDLE, T1..T4, TW, HOLD_ACK)
//   MAX_WAIT_DEFAULT : default number of wait states tolerated before abort
package my_pkg;

  localparam int unsigned MAX_WAIT_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    T1       = 3'd1,
    T2       = 3'd2,
    T3       = 3'd3,
    TW       = 3'd4,
    T4       = 3'd5,
    HOLD_ACK = 3'd6
  } bus_state_t;

endpackage

// File: rtl/bus_master_8088_if.sv
// Request/response handshake plus 8088 bus control signals.
// The multiplexed AD bus is a separate inout port on the master because it
// is bidirectional; ad_oe mirrors the master's AD output enable so a bus
// transceiver (or observer) can follow the drive direction.
//   master modport : the bus master (drives controls, responses, req_ready)
//   slave  modport : the requester / bus slave side
interface bus_master_8088_if;

  // transfer request / response
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;

  // 8088 bus controls (RD, WR, DEN active-low)
  logic [11:0] A;
  logic        ALE;
  logic        IOM;
  logic        RD;
  logic        WR;
  logic        DTR;
  logic        DEN;
  logic        READY;
  logic        HOLD;
  logic        HLDA;
  logic        ad_oe;

  modport master (
    input  req_valid, req_write, req_io, req_addr, req_wdata, READY, HOLD,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output A, ALE, IOM, RD, WR, DTR, DEN, HLDA, ad_oe
  );

  modport slave (
    output req_valid, req_write, req_io, req_addr, req_wdata, READY, HOLD,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  A, ALE, IOM, RD, WR, DTR, DEN, HLDA, ad_oe
  );

endinterface

// File: rtl/bus_wait_timer.sv
// Wait-state counter for one bus cycle.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   clear        : zero the count (asserted while in T1)
//   inc          : count one wait state (asserted while in TW)
//   limit_hit    : the wait state currently being counted is the last one
//                  allowed; with READY still low the cycle must abort
module bus_wait_timer
  import my_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic clear,
  input  logic inc,
  output logic limit_hit
);

  localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [CNT_W-1:0] count_reg;

  // count_reg holds the number of wait states already completed, so the
  // current TW is number count_reg+1.
  assign limit_hit = ((32'(count_reg) + 32'd1) >= MAX_WAIT);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && !limit_hit) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bus_master_8088.sv
// 8088 minimum-mode bus master: turns single-beat requests into
// T1-T2-T3-[TW...]-T4 bus cycles and grants HOLD between cycles.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   bus          : request/response handshake and bus controls (master side)
//   AD           : multiplexed address[7:0] / data bus
//   MAX_WAIT     : wait states tolerated before the cycle is aborted
module bus_master_8088
  import my_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  bus_master_8088_if.master    bus,
  inout  wire [7:0]            AD
);

  bus_state_t  state_reg;
  logic        write_reg;
  logic [7:0]  wdata_reg;
  logic [7:0]  ad_out_reg;
  logic        ad_oe_reg;
  logic [11:0] a_reg;
  logic        ale_reg;
  logic        iom_reg;
  logic        rd_reg;
  logic        wr_reg;
  logic        dtr_reg;
  logic        den_reg;
  logic        hlda_reg;
  logic        rsp_valid_reg;
  logic [7:0]  rsp_rdata_reg;
  logic        rsp_err_reg;

  logic        limit_hit;
  logic        wait_exhausted;

  bus_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .clear     (state_reg == T1),
    .inc       (state_reg == TW),
    .limit_hit (limit_hit)
  );

  // T3 has not consumed a wait state yet; it can only run out of budget
  // when no wait states are allowed at all.
  assign wait_exhausted = (state_reg == TW) ? limit_hit : (MAX_WAIT == 0);

  assign AD = ad_oe_reg ? ad_out_reg : 8'hzz;

  assign bus.req_ready = (state_reg == IDLE) && !bus.HOLD;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.A         = a_reg;
  assign bus.ALE       = ale_reg;
  assign bus.IOM       = iom_reg;
  assign bus.RD        = rd_reg;
  assign bus.WR        = wr_reg;
  assign bus.DTR       = dtr_reg;
  assign bus.DEN       = den_reg;
  assign bus.HLDA      = hlda_reg;
  assign bus.ad_oe     = ad_oe_reg;

  // Bus outputs are registered: each branch sets the values that belong to
  // the state being entered.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg     <= IDLE;
      write_reg     <= 1'b0;
      wdata_reg     <= 8'h00;
      ad_out_reg    <= 8'h00;
      ad_oe_reg     <= 1'b0;
      a_reg         <= 12'h000;
      ale_reg       <= 1'b0;
      iom_reg       <= 1'b0;
      rd_reg        <= 1'b1;
      wr_reg        <= 1'b1;
      dtr_reg       <= 1'b0;
      den_reg       <= 1'b1;
      hlda_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 8'h00;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.HOLD) begin
            state_reg <= HOLD_ACK;
            hlda_reg  <= 1'b1;
          end else if (bus.req_valid) begin
            state_reg  <= T1;
            write_reg  <= bus.req_write;
            wdata_reg  <= bus.req_wdata;
            ale_reg    <= 1'b1;
            ad_out_reg <= bus.req_addr[7:0];
            ad_oe_reg  <= 1'b1;
            a_reg      <= bus.req_addr[19:8];
            iom_reg    <= bus.req_io;
            dtr_reg    <= bus.req_write;
          end
        end

        T1: begin
          state_reg <= T2;
          ale_reg   <= 1'b0;
          den_reg   <= 1'b0;
          if (write_reg) begin
            wr_reg     <= 1'b0;
            ad_out_reg <= wdata_reg;
          end else begin
            rd_reg    <= 1'b0;
            ad_oe_reg <= 1'b0;
          end
        end

        T2: state_reg <= T3;

        T3, TW: begin
          if (bus.READY || wait_exhausted) begin
            state_reg     <= T4;
            rd_reg        <= 1'b1;
            wr_reg        <= 1'b1;
            den_reg       <= 1'b1;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= !bus.READY;
            rsp_rdata_reg <= (bus.READY && !write_reg) ? AD : 8'h00;
          end else begin
            state_reg <= TW;
          end
        end

        T4: begin
          ad_oe_reg <= 1'b0;
          // A hold that arrived during the cycle is granted as the cycle
          // ends, releasing the bus right after T4.
          if (bus.HOLD) begin
            state_reg <= HOLD_ACK;
            hlda_reg  <= 1'b1;
          end else begin
            state_reg <= IDLE;
          end
        end

        HOLD_ACK: begin
          if (!bus.HOLD) begin
            state_reg <= IDLE;
            hlda_reg  <= 1'b0;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_8088.sv
// Directed bench for bus_master_8088: memory/IO reads and writes, wait
// states, wait-state timeout, HOLD handling, back-to-back requests and
// reset in the middle of a cycle. Outputs are sampled on the falling edge.
module tb_bus_master_8088;

  localparam int MAX_WAIT = 16;

  logic       CLK;
  logic       RESET_N;
  logic       slave_oe;
  logic [7:0] slave_data;
  wire  [7:0] ad;

  int check_count;
  int pass_count;

  bus_master_8088_if bus ();

  assign ad = slave_oe ? slave_data : 8'hzz;

  bus_master_8088 #(
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus),
    .AD      (ad)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      pass_count++;
    end
  endtask

  // {ALE, RD, WR, DEN, IOM, DTR, ad_oe, HLDA, rsp_valid}
  function automatic logic [8:0] bus_ctl();
    return {bus.ALE, bus.RD, bus.WR, bus.DEN, bus.IOM, bus.DTR, bus.ad_oe, bus.HLDA, bus.rsp_valid};
  endfunction

  // Runs one transfer starting at a falling edge in IDLE and returns at the
  // falling edge inside T4. waits > MAX_WAIT means READY never rises.
  task automatic run_cycle(input logic is_write, input logic is_io, input logic [19:0] addr,
                           input logic [7:0] wdata, input int waits, input logic [7:0] rdata,
                           input bit keep_valid, input int hold_at);
    int         k_t4;
    bit         err;
    logic [7:0] exp_rdata;
    err       = (waits > MAX_WAIT);
    k_t4      = 4 + (err ? MAX_WAIT : waits);
    exp_rdata = (is_write || err) ? 8'h00 : rdata;

    check_value("idle_req_ready", 32'(bus.req_ready), 32'd1);
    check_value("idle_ctl", 32'({bus.ALE, bus.RD, bus.WR, bus.DEN, bus.ad_oe, bus.HLDA, bus.rsp_valid}),
                32'(7'b0111000));
    bus.req_valid = 1'b1;
    bus.req_write = is_write;
    bus.req_io    = is_io;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;

    for (int k = 1; k <= k_t4; k++) begin
      @(negedge CLK);
      if (k == 1 && !keep_valid) bus.req_valid = 1'b0;
      if (k == hold_at) bus.HOLD = 1'b1;
      bus.READY = (!err && k >= 3 + waits);
      if (!is_write && k == 2) begin
        slave_oe   = 1'b1;
        slave_data = rdata;
      end
      if (k == k_t4) slave_oe = 1'b0;

      check_value("A_held", 32'(bus.A), 32'(addr[19:8]));
      check_value("IOM_held", 32'(bus.IOM), 32'(is_io));
      check_value("DTR_held", 32'(bus.DTR), 32'(is_write));
      if (k == 1) begin
        check_value("t1_ctl", 32'({bus.ALE, bus.RD, bus.WR, bus.DEN, bus.ad_oe, bus.HLDA, bus.rsp_valid}),
                    32'(7'b1111100));
        check_value("t1_ad", 32'(ad), 32'(addr[7:0]));
      end else if (k < k_t4) begin
        check_value("data_ctl", 32'({bus.ALE, bus.RD, bus.WR, bus.DEN, bus.ad_oe, bus.HLDA, bus.rsp_valid}),
                    32'({1'b0, is_write, !is_write, 1'b0, is_write, 1'b0, 1'b0}));
        if (is_write) check_value("data_ad", 32'(ad), 32'(wdata));
      end else begin
        check_value("t4_ctl", 32'({bus.ALE, bus.RD, bus.WR, bus.DEN, bus.ad_oe, bus.HLDA, bus.rsp_valid}),
                    32'({1'b0, 1'b1, 1'b1, 1'b1, is_write, 1'b0, 1'b1}));
        if (is_write) check_value("t4_ad", 32'(ad), 32'(wdata));
        check_value("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rdata));
        check_value("rsp_err", 32'(bus.rsp_err), 32'(err));
      end
    end
    $display("txn %s %s addr=%05h wdata=%02h waits=%0d rdata=%02h err=%0d done_cycle=%0d",
             is_write ? "write" : "read ", is_io ? "io " : "mem", addr, wdata, waits,
             bus.rsp_rdata, bus.rsp_err, k_t4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_rsp;
    check_count   = 0;
    pass_count    = 0;
    RESET_N       = 1'b0;
    slave_oe      = 1'b0;
    slave_data    = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_io    = 1'b0;
    bus.req_addr  = 20'h0;
    bus.req_wdata = 8'h00;
    bus.READY     = 1'b1;
    bus.HOLD      = 1'b0;

    // reset state
    @(negedge CLK);
    check_value("reset_ctl", 32'(bus_ctl()), 32'(9'b011100000));
    check_value("reset_A", 32'(bus.A), 32'd0);
    check_value("reset_rdata", 32'(bus.rsp_rdata), 32'd0);
    check_value("reset_err", 32'(bus.rsp_err), 32'd0);
    $display("txn reset ctl=%09b", bus_ctl());
    @(negedge CLK);
    RESET_N = 1'b1;

    // memory read, no wait states
    run_cycle(1'b0, 1'b0, 20'h80010, 8'h00, 0, 8'hA5, 1'b0, 0);
    @(negedge CLK);
    check_value("rdata_hold", 32'(bus.rsp_rdata), 32'hA5);
    check_value("rsp_valid_pulse", 32'(bus.rsp_valid), 32'd0);

    // READY never rises: abort after MAX_WAIT wait states
    run_cycle(1'b0, 1'b0, 20'h12345, 8'h00, 99, 8'hEE, 1'b0, 0);
    @(negedge CLK);

    // I/O write with two wait states
    run_cycle(1'b1, 1'b1, 20'h0FF02, 8'h3C, 2, 8'h00, 1'b0, 0);
    @(negedge CLK);

    // back-to-back writes with req_valid held
    run_cycle(1'b1, 1'b0, 20'h00100, 8'h01, 0, 8'h00, 1'b1, 0);
    @(negedge CLK);
    run_cycle(1'b1, 1'b0, 20'h00101, 8'h02, 0, 8'h00, 1'b0, 0);
    @(negedge CLK);

    // HOLD raised during T2 of a read
    run_cycle(1'b0, 1'b0, 20'h40000, 8'h00, 0, 8'h5A, 1'b0, 2);
    @(negedge CLK);
    check_value("hold_ack_ctl", 32'({bus.ALE, bus.RD, bus.WR, bus.DEN, bus.ad_oe, bus.HLDA, bus.rsp_valid}),
                32'(7'b0111010));
    check_value("hold_req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 20'h00042;
    @(negedge CLK);
    check_value("hold_beats_req", 32'({bus.ALE, bus.HLDA}), 32'(2'b01));
    $display("txn hold granted hlda=%0d", bus.HLDA);
    bus.HOLD = 1'b0;
    @(negedge CLK);
    check_value("hold_release_hlda", 32'(bus.HLDA), 32'd0);
    run_cycle(1'b0, 1'b1, 20'h00042, 8'h00, 1, 8'hC3, 1'b0, 0);
    @(negedge CLK);

    // reset during a wait state
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_io    = 1'b1;
    bus.req_addr  = 20'h23456;
    bus.READY     = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      bus.req_valid = 1'b0;
    end
    #2 RESET_N = 1'b0;
    #1;
    check_value("midreset_ctl", 32'(bus_ctl()), 32'(9'b011100000));
    check_value("midreset_A", 32'(bus.A), 32'd0);
    check_value("midreset_rdata", 32'(bus.rsp_rdata), 32'd0);
    check_value("midreset_err", 32'(bus.rsp_err), 32'd0);
    saw_rsp = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      saw_rsp = saw_rsp | bus.rsp_valid;
    end
    check_value("midreset_no_rsp", 32'(saw_rsp), 32'd0);
    $display("txn reset during wait state ctl=%09b", bus_ctl());
    RESET_N   = 1'b1;
    bus.READY = 1'b1;
    run_cycle(1'b0, 1'b0, 20'h80010, 8'h00, 0, 8'h77, 1'b0, 0);
    @(negedge CLK);
    check_value("final_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
